// File: rtl/mips_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mips_bus_pkg                                         |
// | Description : Shared types and constants for the two-master        |
// |               memory bus arbiter.                                  |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package mips_bus_pkg;

  // Encoding chosen so the state bits double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int M_CPU = 0;
  localparam int M_DMA = 1;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : arb_rr_pick                                          |
// | Description : Combinational next-owner selector: round-robin with  |
// |               a bounded number of completions per grant.           |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module arb_rr_pick
  import mips_bus_pkg::*;
#(
  parameter int MAX_HOLD  = 4,
  parameter bit CPU_FIRST = 1'b1
) (
  input  arb_state_t state,
  input  logic [1:0] req,
  input  logic       last,
  input  logic       last_vld,
  input  logic [3:0] hold_cnt,
  input  logic       done,
  output arb_state_t next_state
);

  localparam logic [4:0] HOLD_LIM = 5'(MAX_HOLD);

  logic       own_is1;
  logic       own_req;
  logic       oth_req;
  logic       hold_hit;
  arb_state_t other;

  assign own_is1  = (state == OWN1);
  assign own_req  = own_is1 ? req[M_DMA] : req[M_CPU];
  assign oth_req  = own_is1 ? req[M_CPU] : req[M_DMA];
  assign other    = own_is1 ? OWN0 : OWN1;
  // Saturating counter plus >= keeps the bound even if the owner ran
  // uncontended past the limit before the other master showed up.
  assign hold_hit = (({1'b0, hold_cnt} + 5'd1) >= HOLD_LIM);

  // Next owner from current owner, requests, history and hold count.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          if (last_vld) next_state = last ? OWN0 : OWN1;
          else          next_state = CPU_FIRST ? OWN0 : OWN1;
        end else if (req[M_CPU]) begin
          next_state = OWN0;
        end else if (req[M_DMA]) begin
          next_state = OWN1;
        end else begin
          next_state = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          next_state = IDLE;
        end else if (done) begin
          if (oth_req && hold_hit) next_state = other;
          else if (own_req)        next_state = state;
          else if (oth_req)        next_state = other;
          else                     next_state = IDLE;
        end else begin
          next_state = state;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mips_bus_arbiter                                     |
// | Description : Two-master Avalon-style bus arbiter (CPU + DMA) with |
// |               registered grant and bounded round-robin hold.       |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int MAX_HOLD  = 4,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [1:0]  grant,
  output logic        busy
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       last_vld;
  logic [3:0] hold_cnt;
  logic       busy_q;
  logic [1:0] req;
  logic       own0;
  logic       own1;
  logic       done;
  bus_req_t   m0_req;
  bus_req_t   m1_req;
  bus_req_t   sel_req;

  assign m0_req = '{address: m0_address, read: m0_read, write: m0_write,
                    writedata: m0_writedata, byteenable: m0_byteenable};
  assign m1_req = '{address: m1_address, read: m1_read, write: m1_write,
                    writedata: m1_writedata, byteenable: m1_byteenable};

  assign req[M_CPU] = m0_read | m0_write;
  assign req[M_DMA] = m1_read | m1_write;
  assign own0       = (state == OWN0);
  assign own1       = (state == OWN1);
  assign done       = ((own0 & req[M_CPU]) | (own1 & req[M_DMA])) & ~mem_waitrequest;

  arb_rr_pick #(
    .MAX_HOLD  (MAX_HOLD),
    .CPU_FIRST (CPU_FIRST)
  ) u_pick (
    .state      (state),
    .req        (req),
    .last       (last),
    .last_vld   (last_vld),
    .hold_cnt   (hold_cnt),
    .done       (done),
    .next_state (state_nxt)
  );

  // Owner, history and hold-count registers; reset forces the bus idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b0;
      last_vld <= 1'b0;
      hold_cnt <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      if (done) begin
        last     <= own1;
        last_vld <= 1'b1;
      end
      if ((state_nxt != state) || (state_nxt == IDLE)) begin
        hold_cnt <= 4'd0;
      end else if (done && (hold_cnt != 4'hF)) begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

  // Only the owner's request reaches memory; a non-owner's inputs never do.
  always_comb begin
    sel_req = '0;
    if (own0)      sel_req = m0_req;
    else if (own1) sel_req = m1_req;
  end

  // A simultaneous read+write is treated as a write.
  assign mem_address    = sel_req.address;
  assign mem_write      = sel_req.write;
  assign mem_read       = sel_req.read & ~sel_req.write;
  assign mem_writedata  = sel_req.writedata;
  assign mem_byteenable = sel_req.byteenable;

  assign m0_waitrequest = own0 ? mem_waitrequest : 1'b1;
  assign m1_waitrequest = own1 ? mem_waitrequest : 1'b1;
  assign m0_readdata    = own0 ? mem_readdata : 32'd0;
  assign m1_readdata    = own1 ? mem_readdata : 32'd0;

  // State encoding is the one-hot grant, so grant comes straight from flops.
  assign grant = state;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_mips_bus_arbiter                                  |
// | Description : Scoreboard bench for mips_bus_arbiter: directed       |
// |               scenarios plus randomized two-master traffic.        |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_mips_bus_arbiter;

  localparam int TB_MAX_HOLD = 4;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [1:0]  grant;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   comp_log[$];
  int   prev_own = -1;
  int   cont = 0;
  bit   rd_fixed_en = 1'b0;
  bit   rand_wait = 1'b0;
  int   fixed_wait = 0;

  mips_bus_arbiter #(
    .MAX_HOLD  (TB_MAX_HOLD),
    .CPU_FIRST (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_address      (m0_address),
    .m0_read         (m0_read),
    .m0_write        (m0_write),
    .m0_writedata    (m0_writedata),
    .m0_byteenable   (m0_byteenable),
    .m0_waitrequest  (m0_waitrequest),
    .m0_readdata     (m0_readdata),
    .m1_address      (m1_address),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_writedata    (m1_writedata),
    .m1_byteenable   (m1_byteenable),
    .m1_waitrequest  (m1_waitrequest),
    .m1_readdata     (m1_readdata),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .grant           (grant),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  assign mem_readdata = rd_fixed_en ? 32'hDEAD_BEEF : model_rd(mem_address);

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Memory model: waits a fixed or random number of cycles per transaction.
  initial begin
    int  busy_cnt;
    int  cur_w;
    bit  done_flag;
    busy_cnt = 0; cur_w = 0; done_flag = 1'b0;
    mem_waitrequest = 1'b1;
    forever begin
      @(posedge clk);
      if (done_flag) busy_cnt = 0;
      done_flag = 1'b0;
      #2;
      if (mem_read || mem_write) begin
        if (busy_cnt == 0) cur_w = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
        mem_waitrequest = (busy_cnt < cur_w);
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        mem_waitrequest = 1'b1;
      end
      @(negedge clk);
      if ((mem_read || mem_write) && !mem_waitrequest) done_flag = 1'b1;
    end
  end

  // Monitor: pops the owner's expected transaction at every completion.
  initial begin
    int   own;
    bit   got;
    bit   other_req;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (mem_read || mem_write) && !mem_waitrequest) begin
        got = 1'b0;
        own = -1;
        if (grant == 2'b01) begin
          own = 0;
          if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        end else if (grant == 2'b10) begin
          own = 1;
          if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        end
        check("owner_expected", {31'd0, got}, 32'd1);
        if (got) begin
          check("mem_address", mem_address, e.addr);
          check("mem_write", {31'd0, mem_write}, {31'd0, e.wr});
          check("mem_read", {31'd0, mem_read}, {31'd0, e.rd & ~e.wr});
          check("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, e.be});
          if (e.wr) check("mem_writedata", mem_writedata, e.wdata);
          else      check("readdata", (own == 0) ? m0_readdata : m1_readdata, e.rdata);
          check("nonowner_wait", {31'd0, (own == 0) ? m1_waitrequest : m0_waitrequest}, 32'd1);
          check("nonowner_rdata", (own == 0) ? m1_readdata : m0_readdata, 32'd0);
          other_req = (own == 0) ? (m1_read | m1_write) : (m0_read | m0_write);
          if (own != prev_own) cont = 0;
          if (other_req) cont++;
          else           cont = 0;
          check("hold_bound", {31'd0, cont <= TB_MAX_HOLD}, 32'd1);
          prev_own = own;
          comp_log.push_back(own);
        end
      end
    end
  end

  task automatic release_m(input int m);
    if (m == 0) begin
      m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
    end else begin
      m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;
    end
  endtask

  // Issue one transaction, push its expectation, wait for completion.
  task automatic do_txn(input int m, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    e.addr = a; e.rd = rd; e.wr = wr; e.wdata = wd; e.be = be;
    e.rdata = rd_fixed_en ? 32'hDEAD_BEEF : model_rd(a);
    if (m == 0) begin
      q0.push_back(e);
      m0_address = a; m0_read = rd; m0_write = wr; m0_writedata = wd; m0_byteenable = be;
    end else begin
      q1.push_back(e);
      m1_address = a; m1_read = rd; m1_write = wr; m1_writedata = wd; m1_byteenable = be;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("txn_timeout", 32'd1, 32'd0);
    release_m(m);
  endtask

  task automatic rand_master(input int m, input int n);
    int kind;
    int gap;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 3);
      do_txn(m, {$urandom_range(0, 16'hFFFF), 2'b00} | (m << 20),
             (kind == 0 || kind == 2 || kind == 3), (kind == 1 || kind == 2),
             $urandom, 4'($urandom_range(1, 15)));
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        release_m(m);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    release_m(m);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    prev_own = -1;
    cont = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int runs[$];
    int owners[$];
    int base;
    reset = 1'b0;
    release_m(0);
    release_m(1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    check("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    check("rst_m0_rdata", m0_readdata, 32'd0);
    reset = 1'b1;
    idle_cycles(2);

    // Single CPU read, two wait cycles, fixed read data.
    rd_fixed_en = 1'b1;
    fixed_wait  = 2;
    fork
      begin do_txn(0, 32'h0000_0040, 1'b1, 1'b0, 32'd0, 4'hF); release_m(0); end
      begin
        @(posedge clk); #1;
        check("t1_grant", {30'd0, grant}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_wait_c1", {31'd0, m0_waitrequest}, 32'd1);
        check("t1_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        @(negedge clk);
        check("t1_wait_c2", {31'd0, m0_waitrequest}, 32'd1);
        @(negedge clk);
        check("t1_wait_c3", {31'd0, m0_waitrequest}, 32'd0);
        check("t1_rdata", m0_readdata, 32'hDEAD_BEEF);
        check("t1_m1_wait_end", {31'd0, m1_waitrequest}, 32'd1);
      end
    join
    rd_fixed_en = 1'b0;
    idle_cycles(3);

    // Simultaneous first requests from a fresh reset: CPU first.
    reset_dut();
    fixed_wait = 1;
    comp_log.delete();
    fork
      begin do_txn(0, 32'h0000_0080, 1'b1, 1'b0, 32'd0, 4'hF); release_m(0); end
      begin do_txn(1, 32'h0000_0084, 1'b1, 1'b0, 32'd0, 4'h3); release_m(1); end
      begin @(posedge clk); #1; check("t2_first_grant", {30'd0, grant}, 32'd1); end
    join
    check("t2_count", comp_log.size(), 2);
    check("t2_order0", (comp_log.size() > 0) ? comp_log[0] : -1, 0);
    check("t2_order1", (comp_log.size() > 1) ? comp_log[1] : -1, 1);
    idle_cycles(3);

    // DMA read+write together: forwarded as a single write.
    base = comp_log.size();
    fork
      begin do_txn(1, 32'h0000_0100, 1'b1, 1'b1, 32'h1234_5678, 4'hF); release_m(1); end
      begin
        @(posedge clk); @(negedge clk);
        check("t3_mem_write", {31'd0, mem_write}, 32'd1);
        check("t3_mem_read", {31'd0, mem_read}, 32'd0);
      end
    join
    idle_cycles(3);
    check("t3_one_txn", comp_log.size() - base, 1);

    // Leave history pointing at the CPU, then reset mid-write.
    do_txn(0, 32'h0000_0010, 1'b1, 1'b0, 32'd0, 4'hF);
    release_m(0);
    idle_cycles(3);
    fixed_wait = 5;
    m0_address = 32'h0000_0200; m0_write = 1'b1; m0_writedata = 32'hCAFE_0001; m0_byteenable = 4'hF;
    @(posedge clk); #1;
    check("t4_grant", {30'd0, grant}, 32'd1);
    @(posedge clk); #1;
    check("t4_writing", {31'd0, mem_write}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t4_rst_write", {31'd0, mem_write}, 32'd0);
    check("t4_rst_grant", {30'd0, grant}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    check("t4_rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    release_m(0);
    @(posedge clk); #1;
    reset = 1'b1;
    fixed_wait = 0;
    fork
      begin do_txn(0, 32'h0000_0300, 1'b1, 1'b0, 32'd0, 4'hF); release_m(0); end
      begin do_txn(1, 32'h0000_0304, 1'b0, 1'b1, 32'h5555_AAAA, 4'hC); release_m(1); end
      begin @(posedge clk); #1; check("t4_rearb_grant", {30'd0, grant}, 32'd1); end
    join
    idle_cycles(3);

    // Owner drops its read mid-wait: IDLE, then the pending DMA.
    fixed_wait = 5;
    m0_address = 32'h0000_0400; m0_read = 1'b1; m0_byteenable = 4'hF;
    fork
      begin
        @(posedge clk); #1;
        do_txn(1, 32'h0000_0404, 1'b1, 1'b0, 32'd0, 4'hF);
        release_m(1);
      end
      begin
        @(posedge clk); #1;
        check("t5_grant0", {30'd0, grant}, 32'd1);
        @(posedge clk); #1;
        release_m(0);
        fixed_wait = 0;
        @(posedge clk); #1;
        check("t5_idle", {30'd0, grant}, 32'd0);
        @(posedge clk); #1;
        check("t5_grant1", {30'd0, grant}, 32'd2);
      end
    join
    idle_cycles(3);

    // Both stream with zero-wait memory: runs of exactly MAX_HOLD.
    reset_dut();
    fixed_wait = 0;
    comp_log.delete();
    fork
      begin
        for (int k = 0; k < 12; k++)
          do_txn(0, 32'h0000_1000 + 32'(k * 4), ~k[0], k[0], 32'(k), 4'hF);
        release_m(0);
      end
      begin
        for (int k = 0; k < 12; k++)
          do_txn(1, 32'h0000_2000 + 32'(k * 4), k[0], ~k[0], 32'(k + 100), 4'hF);
        release_m(1);
      end
    join
    foreach (comp_log[i]) begin
      if (i == 0 || comp_log[i] != comp_log[i - 1]) begin
        runs.push_back(1);
        owners.push_back(comp_log[i]);
      end else begin
        runs[runs.size() - 1]++;
      end
    end
    check("stream_runs", runs.size(), 6);
    check("stream_first", (owners.size() > 0) ? owners[0] : -1, 0);
    for (int i = 0; i < runs.size(); i++) check("stream_run_len", runs[i], TB_MAX_HOLD);
    idle_cycles(3);

    // Randomized traffic with random memory latency.
    reset_dut();
    rand_wait = 1'b1;
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    idle_cycles(5);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter sharing the single Avalon-style memory bus between the `mips_cpu_bus` core (master 0) and a DMA/debug loader (master 1). It sits between both masters and the memory. It registers the grant, routes request and response signals, and holds non-granted masters in wait. Arbitration is round-robin with a bounded hold, so neither master can starve the other.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum back-to-back completed transactions per grant while the other master is requesting (1..15).
- `CPU_FIRST`, default 1: winner on a simultaneous request out of reset, when no history exists (1 = master 0).

Ports (clk and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `m0_address`, `m1_address` in 32: master byte address.
- `m0_read`, `m1_read` in 1: read request.
- `m0_write`, `m1_write` in 1: write request.
- `m0_writedata`, `m1_writedata` in 32: write data.
- `m0_byteenable`, `m1_byteenable` in 4: byte lanes.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall to master.
- `m0_readdata`, `m1_readdata` out 32: read data to master.
- `mem_address` out 32, `mem_read` out 1, `mem_write` out 1, `mem_writedata` out 32, `mem_byteenable` out 4: memory side.
- `mem_waitrequest` in 1, `mem_readdata` in 32: memory response.
- `grant` out 2: one-hot current owner; 00 = none.
- `busy` out 1: a grant is held.

## Operation
- State machine states: IDLE, OWN0, OWN1. Registers: state, `last` (last owner, 1 bit), `hold_cnt` (4 bits).
- Request: `req_i = mi_read | mi_write`.
- IDLE: no request keeps IDLE. One request goes to OWNi. Two requests pick the master ≠ `last`; with no history, pick per `CPU_FIRST`.
- Completion while in OWNi: `req_i` high and `mem_waitrequest` low. At the completion edge:
  - `hold_cnt` increments and `last` ← i.
  - Go to OWN(other) if the other master requests and `hold_cnt+1 == MAX_HOLD`.
  - Otherwise stay in OWNi if `req_i` is still high.
  - Otherwise go to OWN(other) if the other requests, else IDLE.
  - `hold_cnt` clears on any owner change or on IDLE.
- Other master requests while `req_i` is also high: the arbiter remains in OWNi until completion. There is no preemption mid-transaction.
- Owner drops its request without completion (protocol violation): release to IDLE next edge. No completion is counted.
- Routing in OWNi (combinational from registered state):
  - `mem_*` = `mi_*`.
  - `mi_waitrequest` = `mem_waitrequest`.
  - `mi_readdata` = `mem_readdata`.
- Non-owner: `waitrequest` = 1 and `readdata` = 0.
- In IDLE: `mem_read` = `mem_write` = 0, `mem_address`/`writedata`/`byteenable` = 0, both `waitrequest` = 1.
- Owner asserts read and write together: write is forwarded, `mem_read` is forced 0. It counts as one transaction.
- Reset asserted (low), including mid-transaction: immediately state = IDLE, `last` = none, `hold_cnt` = 0, `grant` = 00, `busy` = 0, `mem_read` = `mem_write` = 0, both `waitrequest` = 1, both `readdata` = 0.

## Timing
- Arbitration latency is one cycle. A request first seen at edge n from IDLE produces `mem_read`/`mem_write` in cycle n+1.
- Owner switch at a completion edge is bubble-free. The new owner's request is on `mem_*` in the next cycle.
- Zero-wait memory (`mem_waitrequest` low) gives one transaction per cycle to the same owner.
- `readdata` is valid in the cycle `waitrequest` is low. There is no pipelined read latency.
- `grant` and `busy` are registered outputs.
- All other outputs are combinational from registered state plus the owner's inputs. There is no combinational path from a non-owner's inputs to `mem_*`.

## Structure
- Shared package `mips_bus_pkg` holds:
  - `arb_state_t` enum (IDLE, OWN0, OWN1).
  - Localparams `M_CPU = 0` and `M_DMA = 1`.
  - A struct `bus_req_t` bundling address, read, write, writedata and byteenable.
- Natural sub-module: `arb_rr_pick`, a combinational next-owner selector. Inputs: `req[1:0]`, `last`, `hold_cnt`, `MAX_HOLD`. Output: next state.

## Test plan
- Single CPU read from IDLE, memory waits 2 cycles, `readdata` 0xDEADBEEF: `grant` 01 one cycle after request; `m0_waitrequest` high 2 cycles then low with `m0_readdata` 0xDEADBEEF; `m1_waitrequest` high throughout.
- Simultaneous first requests, `CPU_FIRST` = 1: master 0 served first, master 1 granted on the completion edge with no idle cycle.
- Both masters stream continuously, zero-wait memory, `MAX_HOLD` = 4: grants alternate in runs of exactly 4 completions each.
- DMA asserts read and write together to 0x100, writedata 0x12345678: `mem_write` = 1, `mem_read` = 0, one transaction counted.
- Reset pulled low while `mem_waitrequest` is high mid-write: same cycle `mem_write` = 0, `grant` = 00, both `waitrequest` = 1; after release, an idle bus re-arbitrates per `CPU_FIRST`.
- Owner drops read while waiting: IDLE next edge; a pending master 1 request is granted the following cycle.
